// File: rtl/slink_frm_pkg.sv
// Shared SLINK frame layout: control/header bit positions, receiver states and
// the default payload limit.
package slink_frm_pkg;

    localparam int unsigned SOF_BIT = 17;
    localparam int unsigned EOF_BIT = 16;
    localparam int unsigned DST_HI  = 15;
    localparam int unsigned DST_LO  = 12;
    localparam int unsigned TYPE_HI = 11;
    localparam int unsigned TYPE_LO = 8;

    localparam int unsigned MAX_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_BODY = 3'd2,
        ST_CSUM = 3'd3,
        ST_DROP = 3'd4
    } rx_state_t;

endpackage

// File: rtl/frm_csum16.sv
// 16-bit wrap-around frame checksum: loads on the header, accumulates length
// and payload words, and compares the running sum against the presented word.
module frm_csum16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] sum,
    output logic        match
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (load) begin
            sum <= word;
        end else if (add) begin
            sum <= sum + word;
        end
    end

    assign match = (sum == word);

endmodule

// File: rtl/ex_cfg_rx.sv
// EX box configuration receiver: parses SLINK frames addressed to this slot and
// writes the payload into the shadow bank of a double-buffered config RAM.
module ex_cfg_rx #(
    parameter int unsigned TMO_CYC = 1024,
    parameter int unsigned MAX_LEN = slink_frm_pkg::MAX_LEN
) (
    input  logic        clk_125m,
    input  logic        rst_125m_n,
    input  logic [3:0]  box_slot,
    input  logic        slink_mm_empty,
    output logic        slink_mm_rdreq,
    input  logic        slink_mm_dval,
    input  logic [17:0] slink_mm_data,
    output logic        cfg_wr_en,
    output logic [8:0]  cfg_wr_addr,
    output logic [15:0] cfg_wr_data,
    output logic        cfg_bank,
    output logic [8:0]  cfg_len,
    output logic [3:0]  cfg_type,
    output logic        frm_ok,
    output logic        frm_err,
    output logic [7:0]  err_cnt,
    output logic        rx_active
);

    import slink_frm_pkg::*;

    localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [1:0]    rst_sync;
    logic          rst_n_s;
    rx_state_t     state;
    logic [TW-1:0] tmo_cnt;
    logic [8:0]    len_l;
    logic [8:0]    cnt;
    logic [8:0]    cnt_nx;
    logic [3:0]    type_l;
    logic [15:0]   word;
    logic          sof;
    logic          eof;
    logic          hdr_hit;
    logic          len_bad;
    logic          active;
    logic          csum_load;
    logic          csum_add;
    logic          csum_match;
    logic [15:0]   csum_sum;

    // Assertion is immediate, release is retimed through two flops.
    always_ff @(posedge clk_125m or negedge rst_125m_n) begin
        if (!rst_125m_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_s        = rst_sync[1];
    assign slink_mm_rdreq = rst_n_s & ~slink_mm_empty;

    assign word    = slink_mm_data[15:0];
    assign sof     = slink_mm_data[SOF_BIT];
    assign eof     = slink_mm_data[EOF_BIT];
    assign hdr_hit = sof && (word[DST_HI:DST_LO] == box_slot);
    assign len_bad = (word == '0) || (32'(word) > MAX_LEN);
    assign cnt_nx  = cnt + 9'd1;
    assign active  = (state == ST_LEN) || (state == ST_BODY) || (state == ST_CSUM);

    assign csum_load = slink_mm_dval && hdr_hit && (state != ST_DROP);
    assign csum_add  = slink_mm_dval && !sof && ((state == ST_LEN) || (state == ST_BODY));

    frm_csum16 u_csum (
        .clk   (clk_125m),
        .rst_n (rst_n_s),
        .load  (csum_load),
        .add   (csum_add),
        .word  (word),
        .sum   (csum_sum),
        .match (csum_match)
    );

    always_ff @(posedge clk_125m or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            len_l       <= '0;
            cnt         <= '0;
            type_l      <= '0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_bank    <= 1'b0;
            cfg_len     <= '0;
            cfg_type    <= '0;
            frm_ok      <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            frm_ok    <= 1'b0;
            frm_err   <= 1'b0;
            cfg_wr_en <= 1'b0;
            if (slink_mm_dval) begin
                tmo_cnt <= '0;
                // A header restarts parsing from any state except DROP; it is
                // only an error when it cuts a frame short.
                if (sof && (state != ST_DROP)) begin
                    frm_err <= (state != ST_IDLE);
                    state   <= hdr_hit ? ST_LEN : ST_DROP;
                    type_l  <= word[TYPE_HI:TYPE_LO];
                end else begin
                    case (state)
                        ST_IDLE: begin
                            frm_err <= 1'b1;
                        end
                        ST_LEN: begin
                            if (eof) begin
                                frm_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else if (len_bad) begin
                                frm_err <= 1'b1;
                                state   <= ST_DROP;
                            end else begin
                                len_l <= word[8:0];
                                cnt   <= '0;
                                state <= ST_BODY;
                            end
                        end
                        ST_BODY: begin
                            if (eof) begin
                                frm_err <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                cfg_wr_en   <= 1'b1;
                                cfg_wr_addr <= {~cfg_bank, cnt[7:0]};
                                cfg_wr_data <= word;
                                cnt         <= cnt_nx;
                                if (cnt_nx == len_l) begin
                                    state <= ST_CSUM;
                                end
                            end
                        end
                        ST_CSUM: begin
                            if (!eof) begin
                                frm_err <= 1'b1;
                                state   <= ST_DROP;
                            end else if (csum_match) begin
                                frm_ok   <= 1'b1;
                                cfg_bank <= ~cfg_bank;
                                cfg_len  <= len_l;
                                cfg_type <= type_l;
                                state    <= ST_IDLE;
                            end else begin
                                frm_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                        ST_DROP: begin
                            if (eof) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end else if (active) begin
                if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                    frm_err <= 1'b1;
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n_s) begin
        if (!rst_n_s) begin
            err_cnt <= '0;
        end else if (frm_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign rx_active = active;

endmodule

// File: doc/ex_cfg_rx.md
EX_CFG_RX -- requirements
Module: ex_cfg_rx

Interface
REQ-001 The block SHALL have parameter TMO_CYC, default 1024, giving the mid-frame inter-word timeout in clk_125m cycles.
REQ-002 The block SHALL have parameter MAX_LEN, default 256, giving the maximum payload words per frame.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk_125m: input, 1 bit, sole clock.
REQ-005 Port rst_125m_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port box_slot: input, 4 bits, own EX box slot number; static.
REQ-007 Port slink_mm_empty: input, 1 bit, SLINK receive FIFO empty.
REQ-008 Port slink_mm_rdreq: output, 1 bit, FIFO read request.
REQ-009 Port slink_mm_dval: input, 1 bit, read word valid, exactly 1 cycle after rdreq.
REQ-010 Port slink_mm_data: input, 18 bits; [17] = SOF, [16] = EOF, [15:0] = word.
REQ-011 Port cfg_wr_en: output, 1 bit, config RAM write strobe.
REQ-012 Port cfg_wr_addr: output, 9 bits; [8] = shadow bank, [7:0] = payload index.
REQ-013 Port cfg_wr_data: output, 16 bits, payload word.
REQ-014 Port cfg_bank: output, 1 bit, bank holding the last good frame.
REQ-015 Port cfg_len: output, 9 bits, payload length of the last good frame.
REQ-016 Port cfg_type: output, 4 bits, frame type of the last good frame.
REQ-017 Port frm_ok: output, 1 bit, 1-cycle pulse on each accepted frame.
REQ-018 Port frm_err: output, 1 bit, 1-cycle pulse on each erroneous frame.
REQ-019 Port err_cnt: output, 8 bits, saturating error count.
REQ-020 Port rx_active: output, 1 bit, high while a frame is in progress.

Function
REQ-021 The frame format SHALL be:
- W0 header: SOF=1; [15:12] dst slot, [11:8] type, [7:0] reserved.
- W1: payload length N.
- N payload words.
- Checksum word: EOF=1; 16-bit wrap sum of W0, W1 and all payload words.
REQ-022 slink_mm_rdreq SHALL equal ~slink_mm_empty in every state except after reset; reads are continuous and back-to-back.
REQ-023 The FSM SHALL have states IDLE, LEN, BODY, CSUM, DROP. All transitions SHALL be evaluated only on cycles with slink_mm_dval=1, except the timeout in REQ-030.
REQ-024 IDLE:
- Word with SOF=1 and dst==box_slot -> LEN; latch type; checksum accumulator <= W0.
- Word with SOF=1 and dst!=box_slot -> DROP, with no error.
- Word with SOF=0 -> discarded, frm_err pulse.
REQ-025 LEN: a length N with N==0 or N>MAX_LEN, or a word with EOF=1, SHALL give frm_err and go to DROP (or to IDLE if EOF=1). Otherwise latch N and go to BODY.
REQ-026 BODY: each word SHALL produce, 1 cycle after its dval:
- cfg_wr_en=1;
- cfg_wr_addr = {~cfg_bank, idx};
- cfg_wr_data = word.
idx starts at 0 and increments. After the Nth word, go to CSUM. A word with EOF=1 in BODY SHALL give frm_err and go to IDLE.
REQ-027 CSUM: checksum word with EOF=1 and a match SHALL, 1 cycle after dval:
- pulse frm_ok;
- toggle cfg_bank;
- load cfg_len and cfg_type.
A mismatch, or EOF=0, SHALL pulse frm_err, leave cfg_bank unchanged, and return to IDLE (EOF=0 goes to DROP).
REQ-028 DROP: words SHALL be consumed with no writes until a word with EOF=1, then go to IDLE.
REQ-029 A word with SOF=1 received in LEN, BODY or CSUM SHALL pulse frm_err, abort the current frame, and be handled as a fresh header per REQ-024.
REQ-030 In LEN, BODY or CSUM, a run of TMO_CYC consecutive cycles without dval SHALL pulse frm_err and force IDLE. The timeout counter SHALL clear on each dval.
REQ-031 err_cnt SHALL increment on every frm_err and saturate at 255.
REQ-032 rx_active SHALL be 1 in LEN, BODY and CSUM.
REQ-033 frm_ok and frm_err SHALL never be asserted in the same cycle.

Reset
REQ-034 While rst_125m_n=0, every output and all state SHALL be 0 and the FSM SHALL be in IDLE. An in-flight frame SHALL be abandoned with no frm_err.
REQ-035 Deassertion of reset SHALL be synchronised internally. slink_mm_rdreq SHALL stay 0 for the first 2 cycles after deassertion.

Structure
REQ-036 The SOF/EOF bit positions, the header field positions, the FSM state encodings and MAX_LEN SHALL be defined in the shared package slink_frm_pkg.
REQ-037 The checksum accumulator and comparator SHALL be a sub-module named frm_csum16.

Verification
REQ-038 Reset with box_slot=3, then send header 0x3100 (SOF), length 0x0002, payload 0x1111, 0x2222, checksum 0x6435 (EOF). Required: writes (0x100, 0x1111) and (0x101, 0x2222); frm_ok; cfg_bank=1; cfg_len=2; cfg_type=1.
REQ-039 Send the REQ-038 frame with checksum 0x6436. Required: frm_err; err_cnt=1; cfg_bank unchanged.
REQ-040 Send header 0x5100 with box_slot=3. Required: words consumed; no writes; no frm_ok or frm_err.
REQ-041 Send length 0x0000, then length 0x0101. Required: frm_err each time; DROP until EOF.
REQ-042 Stop data after the first payload word for TMO_CYC cycles. Required: frm_err and IDLE; a following good frame is accepted.
REQ-043 Inject 256 errors. Required: err_cnt holds at 255.
